// File: rtl/rev_pe_pkg.sv
// Shared types and constants for the reversible-PE batch sequencer.
package rev_pe_pkg;

    // Sequencer control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Result handling modes selected by cfg_mode
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_MAC = 1'b1;

    // Default geometry for top-level reuse
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

endpackage

// File: rtl/rev_pe_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module rev_pe_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise increment until all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/rev_pe_seq.sv
// Batch sequencer: streams operand pairs from the input buffer into the
// reversible datapath, writes results (MUL or MAC prefix sums) into the
// output buffer, counts reverse-check errors and guards the drain phase
// with an idle timeout.
module rev_pe_seq
    import rev_pe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ERR_W  = 8,
    parameter int TMO_W  = 4,
    localparam int ACC_W = 2*DATA_W + ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   cfg_len,
    input  logic                cfg_mode,
    output logic                in_ren,
    output logic [ADDR_W-1:0]   in_raddr,
    input  logic [2*DATA_W-1:0] in_rdata,
    output logic                dp_valid,
    output logic [DATA_W-1:0]   dp_a,
    output logic [DATA_W-1:0]   dp_b,
    input  logic                dp_res_valid,
    input  logic [2*DATA_W-1:0] dp_res,
    input  logic                dp_err1,
    input  logic                dp_err2,
    output logic                out_wen,
    output logic [ADDR_W-1:0]   out_waddr,
    output logic [ACC_W-1:0]    out_wdata,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [ERR_W-1:0]    err1_cnt,
    output logic [ERR_W-1:0]    err2_cnt
);

    localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                timeout_q, timeout_d;
    logic                dp_valid_q, dp_valid_d;

    logic                start_ok;
    logic                res_take;
    logic [ACC_W-1:0]    res_ext;
    logic [ACC_W-1:0]    acc_sum;
    logic [TMO_W-1:0]    tmo_inc;

    // Results are only accepted while a batch is actively issuing or draining
    assign start_ok = (state_q == ST_IDLE) && start;
    assign res_take = dp_res_valid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
    assign res_ext  = {{ADDR_W{1'b0}}, dp_res};
    assign acc_sum  = acc_q + res_ext;
    assign tmo_inc  = tmo_cnt_q + 1'b1;

    // Next-state and counter update; abort overrides every transition
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        mode_d     = mode_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        acc_d      = acc_q;
        tmo_cnt_d  = tmo_cnt_q;
        timeout_d  = timeout_q;
        dp_valid_d = (state_q == ST_ISSUE) && !abort;

        if (res_take) begin
            wr_cnt_d  = wr_cnt_q + 1'b1;
            tmo_cnt_d = '0;
            if (mode_q == MODE_MAC) begin
                acc_d = acc_sum;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d     = cfg_len;
                    mode_d    = cfg_mode;
                    rd_cnt_d  = '0;
                    wr_cnt_d  = '0;
                    acc_d     = '0;
                    tmo_cnt_d = '0;
                    timeout_d = 1'b0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (rd_cnt_q == len_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (res_take) begin
                    if (wr_cnt_q == len_q) begin
                        state_d = ST_DONE;
                    end
                end else if (tmo_inc == TMO_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            timeout_d = timeout_q;
        end
    end

    // State and datapath-control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            mode_q     <= MODE_MUL;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            acc_q      <= '0;
            tmo_cnt_q  <= '0;
            timeout_q  <= 1'b0;
            dp_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            acc_q      <= acc_d;
            tmo_cnt_q  <= tmo_cnt_d;
            timeout_q  <= timeout_d;
            dp_valid_q <= dp_valid_d;
        end
    end

    // Outputs are gated by their strobes so idle buses stay at zero
    assign in_ren    = (state_q == ST_ISSUE);
    assign in_raddr  = in_ren ? rd_cnt_q : '0;
    assign dp_valid  = dp_valid_q;
    assign dp_a      = dp_valid_q ? in_rdata[DATA_W-1:0] : '0;
    assign dp_b      = dp_valid_q ? in_rdata[2*DATA_W-1:DATA_W] : '0;
    assign out_wen   = res_take;
    assign out_waddr = res_take ? wr_cnt_q : '0;
    assign out_wdata = !res_take ? '0 : ((mode_q == MODE_MAC) ? acc_sum : res_ext);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE) && !abort;
    assign timeout   = timeout_q;

    rev_pe_sat_cnt #(.W(ERR_W)) u_err1_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .inc (res_take && dp_err1),
        .cnt (err1_cnt)
    );

    rev_pe_sat_cnt #(.W(ERR_W)) u_err2_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .inc (res_take && dp_err2),
        .cnt (err2_cnt)
    );

endmodule
